// File: rtl/bp_coh_channel_concentrator.sv
// Multiplexes els_p wormhole coherence channels onto one ready-and link and
// demultiplexes the reverse link through a single-entry buffer.
module bp_coh_channel_concentrator #(
  parameter int els_p        = 4,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_pos_p    = 0,
  parameter int rr_p         = 1,
  localparam int cid_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [els_p*flit_width_p-1:0]       tile_data_i,
  input  logic [els_p-1:0]                    tile_v_i,
  output logic [els_p-1:0]                    tile_ready_and_o,
  output logic [els_p*flit_width_p-1:0]       tile_data_o,
  output logic [els_p-1:0]                    tile_v_o,
  input  logic [els_p-1:0]                    tile_ready_and_i,
  output logic [cid_width_lp+flit_width_p-1:0] net_data_o,
  output logic                                net_v_o,
  input  logic                                net_ready_and_i,
  input  logic [cid_width_lp+flit_width_p-1:0] net_data_i,
  input  logic                                net_v_i,
  output logic                                net_ready_and_o,
  output logic                                err_o
);

  // TX state
  logic                    lock_q, lock_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;
  logic [cid_width_lp-1:0] gnt_q, gnt_d;
  logic [cid_width_lp-1:0] ptr_q, ptr_d;

  // RX state
  logic                    buf_v_q, buf_v_d;
  logic [cid_width_lp-1:0] buf_cid_q, buf_cid_d;
  logic [flit_width_p-1:0] buf_flit_q, buf_flit_d;
  logic                    err_q, err_d;

  int                      g;
  int                      idx;
  logic                    found;
  logic                    tx_hs;
  logic [flit_width_p-1:0] sel_flit;
  logic [len_width_p-1:0]  hdr_len;

  logic                    buf_bad;
  logic                    drain;
  logic                    capture;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      buf_v_q    <= 1'b0;
      buf_cid_q  <= '0;
      buf_flit_q <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      buf_v_q    <= buf_v_d;
      buf_cid_q  <= buf_cid_d;
      buf_flit_q <= buf_flit_d;
      err_q      <= err_d;
    end
  end

  // Arbitration: a locked channel owns the link even while its valid is low.
  always_comb begin
    g     = 0;
    idx   = 0;
    found = 1'b0;
    if (lock_q) begin
      g     = int'(gnt_q);
      found = tile_v_i[g];
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (rr_p != 0) begin
          idx = int'(ptr_q) + i;
          if (idx >= els_p) idx = idx - els_p;
        end else begin
          idx = i;
        end
        if (!found && tile_v_i[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
  end

  always_comb begin
    sel_flit         = tile_data_i[g*flit_width_p +: flit_width_p];
    hdr_len          = sel_flit[len_pos_p +: len_width_p];
    net_v_o          = found && !reset_i;
    net_data_o       = {cid_width_lp'(g), sel_flit};
    tile_ready_and_o = '0;
    if (!reset_i && (lock_q || found)) tile_ready_and_o[g] = net_ready_and_i;
    tx_hs            = net_v_o && net_ready_and_i;
  end

  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    if (tx_hs) begin
      if (lock_q) begin
        cnt_d = cnt_q - len_width_p'(1);
        if (cnt_q == len_width_p'(1)) lock_d = 1'b0;
      end else begin
        if (hdr_len != '0) begin
          lock_d = 1'b1;
          cnt_d  = hdr_len;
          gnt_d  = cid_width_lp'(g);
        end
        if (rr_p != 0) ptr_d = cid_width_lp'((g == els_p - 1) ? 0 : g + 1);
      end
    end
  end

  // RX: out-of-range ids are dropped without ever being presented.
  always_comb begin
    buf_bad         = buf_v_q && (int'(buf_cid_q) >= els_p);
    drain           = buf_v_q && (buf_bad || tile_ready_and_i[buf_cid_q]);
    net_ready_and_o = !reset_i && (!buf_v_q || drain);
    capture         = net_v_i && net_ready_and_o;

    buf_v_d    = capture || (buf_v_q && !drain);
    buf_cid_d  = capture ? net_data_i[flit_width_p +: cid_width_lp] : buf_cid_q;
    buf_flit_d = capture ? net_data_i[flit_width_p-1:0] : buf_flit_q;
    err_d      = err_q ||
                 (capture && (int'(net_data_i[flit_width_p +: cid_width_lp]) >= els_p));

    tile_v_o = '0;
    if (!reset_i && buf_v_q && !buf_bad) tile_v_o[buf_cid_q] = 1'b1;
    tile_data_o = {els_p{buf_flit_q}};
    err_o       = err_q;
  end

endmodule

// File: doc/bp_coh_channel_concentrator.md
Name: bp_coh_channel_concentrator

Overview:
- Time-multiplexes els_p independent coherence wormhole channels (e.g. req/cmd/fill/resp) from one tile onto a single physical ready-and link, and demultiplexes the reverse link back to per-channel outputs.
- Sits between a tile's per-channel coherence links and a single narrow NoC port.
- Generalises the fixed 4-channel socket hookup: channel count, flit width, length-field position and arbitration mode are all parameters.
- Wormhole packet atomicity is preserved per channel.

Parameters:
- els_p, 4, number of channels (>=2).
- flit_width_p, 64, tile-side flit width.
- len_width_p, 4, width of the header length field.
- len_pos_p, 0, LSB position of the length field in a header flit; the field holds the number of body flits following the header.
- rr_p, 1, 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
- cid_width_lp, `BSG_SAFE_CLOG2(els_p)`, channel-id width (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- tile_data_i  in  els_p*flit_width_p  per-channel flits from tile.
- tile_v_i  in  els_p  per-channel valid.
- tile_ready_and_o  out  els_p  per-channel ready.
- tile_data_o  out  els_p*flit_width_p  per-channel flits to tile.
- tile_v_o  out  els_p  per-channel valid to tile.
- tile_ready_and_i  in  els_p  per-channel tile ready.
- net_data_o  out  cid_width_lp+flit_width_p  {cid, flit} to network.
- net_v_o  out  1  network valid.
- net_ready_and_i  in  1  network ready.
- net_data_i  in  cid_width_lp+flit_width_p  {cid, flit} from network.
- net_v_i  in  1  network valid in.
- net_ready_and_o  out  1  network ready out.
- err_o  out  1  sticky: a flit was received with cid >= els_p.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values: lock=0, remaining count=0, rr pointer=0, rx buffer empty, err_o=0. While reset_i=1: all tile_v_o=0, net_v_o=0, tile_ready_and_o=0, net_ready_and_o=0.

TX path (zero latency; combinational from tile inputs to net outputs):
- Unlocked (IDLE): the arbiter picks one channel g among tile_v_i.
  - rr_p=1: search starts at the rr pointer.
  - rr_p=0: lowest index wins.
  - net_v_o=1, net_data_o={g, tile_data_i[g]}, tile_ready_and_o[g]=net_ready_and_i; all other ready bits are 0.
- Header handshake on g: read len = header[len_pos_p +: len_width_p].
  - len==0: stay IDLE. Single-flit packet; no lock.
  - len>0: enter LOCKED(g) with count=len.
  - rr_p=1: the pointer advances to (g+1) mod els_p, wrapping from els_p-1 to 0, on the header handshake.
- LOCKED(g): only channel g is eligible, even if it deasserts valid mid-packet. Other channels' ready bits are 0.
  - Each body handshake decrements count.
  - The handshake with count==1 returns to IDLE in the next cycle.
- Stall (net_ready_and_i=0): net_v_o and net_data_o hold as driven by the tile. Lock, count and pointer are unchanged.
- Throughput: 1 flit per cycle; back-to-back packets from different channels are allowed with no bubble.

RX path (1-entry buffer, 1-cycle latency):
- net_ready_and_o = buffer empty OR buffer draining this cycle. Full throughput: 1 flit per cycle.
- Buffered flit with cid<els_p: tile_v_o[cid]=1 and tile_data_o[cid]=flit. tile_data_o is the buffered flit on all channels; only tile_v_o is steered.
  - Drains on tile_ready_and_i[cid]. Other channels see tile_v_o=0.
- Buffered flit with cid>=els_p (only possible when els_p is not a power of 2): dropped the cycle after capture, and err_o is set and held until reset.
- Simultaneous drain and fill: the new flit replaces the old one in the same edge; there is no bubble.

Reset mid-operation:
- Any lock and the in-flight packet state are discarded.
- The buffered RX flit is lost.
- After deassertion the block arbitrates afresh from pointer 0.

Test Plan:
1. Single-flit packets: els_p=4, rr_p=1, all tile_v_i=1 with len=0 every cycle -> net cid sequence 0,1,2,3,0; one flit per cycle; exactly one tile_ready_and_o high per cycle.
2. Wormhole lock: ch1 sends a header with len=3 while ch0 and ch2 are valid -> four consecutive net flits with cid=1, then ch2 is granted; ch0 and ch2 ready stay 0 throughout.
3. Locked channel gap and backpressure: ch3 has len=2 and drops valid for 2 cycles after the header, while net_ready_and_i toggles 1,0,1 -> no other channel is granted until the 2nd body flit handshakes; data is held stable during stalls.
4. Fixed priority: rr_p=0, ch0 and ch3 continuously valid with len=0 -> ch0 is always granted and ch3 is starved.
5. RX demux: net_v_i stream with cid 2,0,2 and tile_ready_and_i[2]=0 for 1 cycle -> tile_v_o[2] rises 1 cycle after capture; net_ready_and_o=0 during the stall; order is preserved and no flits are lost.
6. Error and reset: els_p=3, receive cid=3 -> flit is never presented; err_o=1 next cycle and stays 1. Then assert reset_i mid-packet (LOCKED, count=2) -> err_o=0, lock cleared; a new header from another channel is granted the first cycle after reset.
